i2c_master_scheduler: RTL

Round-robin scheduler sharing the single I2C master engine between `NREQ` on-chip requesters. It latches one requester's transaction descriptor and drives the master's configuration inputs. It pulses `transaction_begin`, watches for completion, ACK error, arbitration loss and timeout, retries lost arbitrations, and returns a per-requester completion status. It sits between requester logic and the master's register-side inputs and outputs.

---
 rtl/i2c_master_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master_scheduler.sv
// Round-robin scheduler that shares one I2C master engine between NREQ requesters,
// latching the winner's descriptor and retrying lost arbitrations after a bus-idle backoff.
module i2c_master_scheduler #(
  parameter int NREQ      = 2,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*10-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_addr_mode,
  input  logic [NREQ-1:0]      req_dir,
  input  logic [NREQ*6-1:0]    req_len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [1:0]           status,
  output logic [9:0]           bus_address,
  output logic                 address_mode,
  output logic                 data_direction,
  output logic [7:0]           packet_size,
  output logic                 ms_select,
  output logic                 transaction_begin,
  input  logic                 transaction_begin_clear,
  input  logic                 set_transaction_complete_master,
  input  logic                 set_arbitration_lost,
  input  logic                 ack_error_set_master,
  input  logic                 line_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BEGIN, S_WAIT, S_BACKOFF, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ACK     = 2'b01,
    ST_ARB     = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [3:0]    retry_cnt;
  logic [15:0]   to_cnt;
  logic [7:0]    bo_cnt;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;

  assign ms_select = 1'b1;

  // Round-robin search from rr_ptr; iterating downward lets the nearest requester win.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
    next_ptr = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
  end

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      retry_cnt         <= '0;
      to_cnt            <= '0;
      bo_cnt            <= '0;
      gnt               <= '0;
      done              <= '0;
      status            <= ST_OK;
      transaction_begin <= 1'b0;
      bus_address       <= '0;
      address_mode      <= 1'b0;
      data_direction    <= 1'b0;
      packet_size       <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid && !line_busy) begin
            gnt            <= GNT_ONE << pick_idx;
            bus_address    <= req_addr[10*int'(pick_idx) +: 10];
            address_mode   <= req_addr_mode[pick_idx];
            data_direction <= req_dir[pick_idx];
            packet_size    <= {2'b00, req_len[6*int'(pick_idx) +: 6]};
            rr_ptr         <= next_ptr;
            state          <= S_LOAD;
          end
        end

        S_LOAD: begin
          retry_cnt         <= '0;
          to_cnt            <= '0;
          transaction_begin <= 1'b1;
          state             <= S_BEGIN;
        end

        S_BEGIN: begin
          if (to_cnt == 16'(TIMEOUT)) begin
            transaction_begin <= 1'b0;
            done              <= gnt;
            status            <= ST_TIMEOUT;
            state             <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (transaction_begin_clear) begin
              transaction_begin <= 1'b0;
              state             <= S_WAIT;
            end
          end
        end

        // Event priority: arbitration lost, then NACK, then completion, then timeout.
        S_WAIT: begin
          if (set_arbitration_lost) begin
            if (retry_cnt < 4'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 4'd1;
              bo_cnt    <= '0;
              state     <= S_BACKOFF;
            end else begin
              done   <= gnt;
              status <= ST_ARB;
              state  <= S_DONE;
            end
          end else if (ack_error_set_master) begin
            done   <= gnt;
            status <= ST_ACK;
            state  <= S_DONE;
          end else if (set_transaction_complete_master) begin
            done   <= gnt;
            status <= ST_OK;
            state  <= S_DONE;
          end else if (to_cnt == 16'(TIMEOUT)) begin
            done   <= gnt;
            status <= ST_TIMEOUT;
            state  <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end

        // Any busy cycle restarts the idle run; the retry relaunches with a fresh timeout.
        S_BACKOFF: begin
          if (line_busy) begin
            bo_cnt <= '0;
          end else if (bo_cnt == 8'(BACKOFF - 1)) begin
            bo_cnt            <= '0;
            to_cnt            <= '0;
            transaction_begin <= 1'b1;
            state             <= S_BEGIN;
          end else begin
            bo_cnt <= bo_cnt + 8'd1;
          end
        end

        S_DONE: begin
          gnt   <= '0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
